// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: arms a pseudo-random delay, runs the external ms counter
// from GO until stop, flags early stops as fouls and keeps the best (minimum) time.
module reaction_timer_ctrl #(
  parameter int COUNT_W      = 20,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int FOUL_HOLD_MS = 2000,
  parameter int MAX_MS       = 999999
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick_ms,
  input  logic               start_btn,
  input  logic               stop_btn,
  input  logic               clear_best,
  input  logic [COUNT_W-1:0] ms_count,
  output logic               cnt_clear,
  output logic               cnt_run,
  output logic               go_led,
  output logic               foul_led,
  output logic               new_best,
  output logic [COUNT_W-1:0] best_ms,
  output logic [2:0]         state
);

  localparam int DELAY_W = $clog2(MIN_DELAY_MS + (2 ** RAND_BITS));
  localparam int HOLD_W  = $clog2(FOUL_HOLD_MS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FOUL  = 3'd4
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [15:0]          lfsr_r;
  logic                 start_prev_r, stop_prev_r;
  logic                 start_rise_s, stop_rise_s;
  logic [DELAY_W-1:0]   delay_r, delay_nxt_s, delay_load_s;
  logic [HOLD_W-1:0]    hold_r, hold_nxt_s;
  logic [COUNT_W-1:0]   best_r, best_nxt_s;
  logic                 new_best_r, new_best_nxt_s;
  logic                 cnt_clear_r, cnt_run_r, go_led_r, foul_led_r;

  // Moore decode of a state into {cnt_clear, cnt_run, go_led, foul_led}.
  function automatic logic [3:0] decode_outputs(input state_t s);
    case (s)
      S_IDLE:  decode_outputs = 4'b1000;
      S_ARMED: decode_outputs = 4'b1000;
      S_RUN:   decode_outputs = 4'b0110;
      S_DONE:  decode_outputs = 4'b0000;
      S_FOUL:  decode_outputs = 4'b1001;
      default: decode_outputs = 4'b1000;
    endcase
  endfunction

  assign start_rise_s = start_btn & ~start_prev_r;
  assign stop_rise_s  = stop_btn & ~stop_prev_r;
  assign delay_load_s = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_r[RAND_BITS-1:0]);

  // Next-state, counter and best-time logic.
  always_comb begin
    state_nxt_s    = state_r;
    delay_nxt_s    = delay_r;
    hold_nxt_s     = hold_r;
    best_nxt_s     = best_r;
    new_best_nxt_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_rise_s) begin
          state_nxt_s = S_ARMED;
          delay_nxt_s = delay_load_s;
        end else begin
          state_nxt_s = state_r;
        end
        if (clear_best) begin
          best_nxt_s = {COUNT_W{1'b1}};
        end else begin
          best_nxt_s = best_r;
        end
      end
      S_ARMED: begin
        if (stop_rise_s) begin
          state_nxt_s = S_FOUL;
          hold_nxt_s  = HOLD_W'(FOUL_HOLD_MS);
        end else if (tick_ms) begin
          delay_nxt_s = delay_r - DELAY_W'(1);
          if (delay_r == DELAY_W'(1)) begin
            state_nxt_s = S_RUN;
          end else begin
            state_nxt_s = S_ARMED;
          end
        end else begin
          state_nxt_s = S_ARMED;
        end
      end
      S_RUN: begin
        if (stop_rise_s) begin
          state_nxt_s = S_DONE;
          if (ms_count < best_r) begin
            best_nxt_s     = ms_count;
            new_best_nxt_s = 1'b1;
          end else begin
            best_nxt_s = best_r;
          end
        end else if (ms_count >= COUNT_W'(MAX_MS)) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_FOUL: begin
        if (tick_ms) begin
          hold_nxt_s = hold_r - HOLD_W'(1);
          if (hold_r == HOLD_W'(1)) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_FOUL;
          end
        end else begin
          state_nxt_s = S_FOUL;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, LFSR, edge-detect and registered output update.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= S_IDLE;
      lfsr_r       <= 16'hACE1;
      // Capture the live level so a button held through reset needs a fresh press.
      start_prev_r <= start_btn;
      stop_prev_r  <= stop_btn;
      delay_r      <= {DELAY_W{1'b0}};
      hold_r       <= {HOLD_W{1'b0}};
      best_r       <= {COUNT_W{1'b1}};
      new_best_r   <= 1'b0;
      {cnt_clear_r, cnt_run_r, go_led_r, foul_led_r} <= decode_outputs(S_IDLE);
    end else begin
      state_r      <= state_nxt_s;
      lfsr_r       <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      start_prev_r <= start_btn;
      stop_prev_r  <= stop_btn;
      delay_r      <= delay_nxt_s;
      hold_r       <= hold_nxt_s;
      best_r       <= best_nxt_s;
      new_best_r   <= new_best_nxt_s;
      {cnt_clear_r, cnt_run_r, go_led_r, foul_led_r} <= decode_outputs(state_nxt_s);
    end
  end

  assign state     = state_r;
  assign cnt_clear = cnt_clear_r;
  assign cnt_run   = cnt_run_r;
  assign go_led    = go_led_r;
  assign foul_led  = foul_led_r;
  assign new_best  = new_best_r;
  assign best_ms   = best_r;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl with a behavioural model of the
// ms counter, tick divider, arm-delay LFSR and best-time bookkeeping.
module tb_reaction_timer_ctrl;
  localparam int CW = 20;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FOUL  = 3'd4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tick_ms = 1'b0;
  logic          start_btn = 1'b0;
  logic          stop_btn = 1'b0;
  logic          clear_best = 1'b0;
  logic [CW-1:0] ms_count = '0;
  logic          cnt_clear, cnt_run, go_led, foul_led, new_best;
  logic [CW-1:0] best_ms;
  logic [2:0]    state;

  logic [15:0]   lfsr_m = 16'hACE1;
  logic [1:0]    div_m = 2'd0;
  logic [CW-1:0] best_m = '1;
  int            exp_delay = 0;
  int            n_cmp = 0;
  int            n_mis = 0;

  reaction_timer_ctrl #(
    .COUNT_W(20), .MIN_DELAY_MS(4), .RAND_BITS(2), .FOUL_HOLD_MS(3), .MAX_MS(50)
  ) dut (
    .clock(clock), .reset(reset), .tick_ms(tick_ms), .start_btn(start_btn),
    .stop_btn(stop_btn), .clear_best(clear_best), .ms_count(ms_count),
    .cnt_clear(cnt_clear), .cnt_run(cnt_run), .go_led(go_led), .foul_led(foul_led),
    .new_best(new_best), .best_ms(best_ms), .state(state)
  );

  always #5 clock = ~clock;

  // One ms tick every four clocks.
  always @(posedge clock) begin
    if (reset) begin
      div_m   <= 2'd0;
      tick_ms <= 1'b0;
    end else begin
      div_m   <= div_m + 2'd1;
      tick_ms <= (div_m == 2'd3);
    end
  end

  // External ms counter driven by cnt_clear / cnt_run.
  always @(posedge clock) begin
    if (cnt_clear) ms_count <= '0;
    else if (cnt_run && tick_ms) ms_count <= ms_count + 20'd1;
  end

  // x^16+x^14+x^13+x^11+1 Fibonacci sequence, one step per clock.
  always @(posedge clock) begin
    if (reset) lfsr_m <= 16'hACE1;
    else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    exp_delay = 4 + int'(lfsr_m[1:0]);
    cyc();
    start_btn = 1'b0;
    check("armed_state", 32'(state), 32'(ST_ARMED));
    check("armed_clear", 32'(cnt_clear), 32'd1);
  endtask

  task automatic wait_go();
    int ticks = 0;
    for (int c = 0; c < 400; c++) begin
      if (state == ST_ARMED && tick_ms) ticks++;
      cyc();
      if (state != ST_ARMED) break;
    end
    check("go_state", 32'(state), 32'(ST_RUN));
    check("go_led", 32'(go_led), 32'd1);
    check("go_run_clear", 32'({cnt_run, cnt_clear}), 32'b10);
    check("delay_ticks", 32'(ticks), 32'(exp_delay));
  endtask

  task automatic stop_at(input int target);
    logic exp_nb;
    for (int c = 0; c < 400; c++) begin
      if (ms_count == CW'(target)) break;
      cyc();
    end
    check("stop_cnt", 32'(ms_count), 32'(target));
    stop_btn = 1'b1;
    exp_nb = (CW'(target) < best_m);
    if (exp_nb) best_m = CW'(target);
    cyc();
    stop_btn = 1'b0;
    check("done_state", 32'(state), 32'(ST_DONE));
    check("done_best", 32'(best_ms), 32'(best_m));
    check("done_new_best", 32'(new_best), 32'(exp_nb));
    check("done_outs", 32'({cnt_clear, cnt_run, go_led, foul_led}), 32'd0);
    cyc();
    check("new_best_pulse", 32'(new_best), 32'd0);
    check("done_hold", 32'(ms_count), 32'(target));
  endtask

  initial begin
    int ticks;
    // Reset held two clocks.
    repeat (2) cyc();
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_outs", 32'({cnt_clear, cnt_run, go_led, foul_led, new_best}), 32'b10000);
    check("rst_best", 32'(best_ms), 32'hFFFFF);
    reset = 1'b0;
    repeat (3) cyc();
    check("idle_state", 32'(state), 32'(ST_IDLE));

    // First result, a worse one, then a better one.
    press_start(); wait_go(); stop_at(23);
    press_start(); wait_go(); stop_at(30);
    press_start(); wait_go(); stop_at(12);

    // Early stop: foul for exactly three ticks, buttons ignored meanwhile.
    press_start();
    repeat (2) cyc();
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    check("foul_state", 32'(state), 32'(ST_FOUL));
    check("foul_outs", 32'({cnt_clear, cnt_run, go_led, foul_led}), 32'b1001);
    ticks = 0;
    start_btn = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (state == ST_FOUL && tick_ms) ticks++;
      cyc();
      start_btn = 1'b0;
      if (state != ST_FOUL) break;
    end
    check("foul_ticks", 32'(ticks), 32'd3);
    check("foul_exit", 32'(state), 32'(ST_IDLE));
    check("foul_exit_outs", 32'({cnt_clear, foul_led}), 32'b10);
    check("foul_best", 32'(best_ms), 32'(best_m));

    // Timeout at MAX_MS without a stop.
    press_start(); wait_go();
    for (int c = 0; c < 400; c++) begin
      cyc();
      if (state != ST_RUN) break;
    end
    check("tmo_state", 32'(state), 32'(ST_DONE));
    check("tmo_cnt", 32'(ms_count), 32'd50);
    check("tmo_best", 32'(best_ms), 32'(best_m));
    check("tmo_new_best", 32'(new_best), 32'd0);

    // Simultaneous start and stop in DONE: start wins.
    start_btn = 1'b1;
    stop_btn  = 1'b1;
    exp_delay = 4 + int'(lfsr_m[1:0]);
    cyc();
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    check("startstop_state", 32'(state), 32'(ST_ARMED));
    wait_go();
    stop_at(int'($urandom_range(45, 5)));

    // clear_best honoured in DONE, no pulse.
    clear_best = 1'b1;
    cyc();
    clear_best = 1'b0;
    best_m = '1;
    check("clr_best", 32'(best_ms), 32'hFFFFF);
    check("clr_new_best", 32'(new_best), 32'd0);

    // Randomised rounds; clear_best in RUN must be ignored.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(7, 0)) cyc();
      press_start();
      wait_go();
      if (r == 3) begin
        clear_best = 1'b1;
        cyc();
        clear_best = 1'b0;
        cyc();
        check("clr_in_run", 32'(best_ms), 32'(best_m));
      end
      stop_at(int'($urandom_range(45, 5)));
    end

    // Reset during RUN with start held through it.
    press_start(); wait_go();
    repeat ($urandom_range(5, 1)) cyc();
    reset = 1'b1;
    start_btn = 1'b1;
    cyc();
    check("mid_rst_state", 32'(state), 32'(ST_IDLE));
    check("mid_rst_outs", 32'({cnt_clear, cnt_run, go_led, foul_led}), 32'b1000);
    check("mid_rst_best", 32'(best_ms), 32'hFFFFF);
    reset = 1'b0;
    best_m = '1;
    repeat (5) cyc();
    check("held_start", 32'(state), 32'(ST_IDLE));
    start_btn = 1'b0;
    cyc();
    press_start(); wait_go(); stop_at(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
